// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to compile in the even-parity bit.
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              tx_n, busy_n, done_n;
    logic              bit_end;
`ifdef UART_TX_PARITY_EN
    logic              par, par_n;
`endif

    assign bit_end = (cnt == CNT_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
            tx    <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
            tx    <= tx_n;
            busy  <= busy_n;
            done  <= done_n;
`ifdef UART_TX_PARITY_EN
            par   <= par_n;
`endif
        end
    end

    // tx is registered, so each transition loads the level of the bit being entered
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        tx_n    = tx;
        busy_n  = busy;
        done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_n   = par;
`endif
        if (state != IDLE) begin
            cnt_n = bit_end ? '0 : cnt + 1'b1;
        end
        unique case (state)
            IDLE: begin
                tx_n   = 1'b1;
                busy_n = 1'b0;
                if (start) begin
                    state_n = START;
                    shreg_n = data_in;
                    cnt_n   = '0;
                    idx_n   = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
`ifdef UART_TX_PARITY_EN
                    par_n   = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    state_n = DATA;
                    tx_n    = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    shreg_n = shreg >> 1;
                    if (idx == IDX_MAX) begin
                        idx_n = '0;
`ifdef UART_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = par;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        idx_n = idx + 1'b1;
                        tx_n  = shreg[1];
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    state_n = IDLE;
                    tx_n    = 1'b1;
                    busy_n  = 1'b0;
                    done_n  = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                tx_n    = 1'b1;
                busy_n  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: directed steps plus random words against a frame-level model.
module tb_uart_tx;

    localparam int C  = 4;
    localparam int DW = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NB = DW + 3;
`else
    localparam int NB = DW + 2;
`endif
    localparam int FC = NB * C;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          tx, busy, done;

    int vectors = 0;
    int miscompares = 0;

    uart_tx #(.CLKS_PER_BIT(C), .DATA_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Frame bit j of word d: 0 = start, 1..DW = data LSB first, then parity, then stop.
    function automatic logic ref_bit(input logic [DW-1:0] d, input int j);
        if (j == 0) return 1'b0;
        if (j <= DW) return d[j-1];
`ifdef UART_TX_PARITY_EN
        if (j == DW + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        repeat (n) begin
            @(posedge clk);
            #1;
            chk({tag, " tx"}, tx, 1'b1);
            chk({tag, " busy"}, busy, 1'b0);
            chk({tag, " done"}, done, 1'b0);
        end
    endtask

    // Sends d; data_in is scrambled while busy, start optionally held or poked at cycle poke.
    task automatic frame(input logic [DW-1:0] d, input bit keep,
                         input logic [DW-1:0] next_d, input int poke);
        start   = 1'b1;
        data_in = d;
        for (int t = 1; t <= FC + 1; t++) begin
            @(posedge clk);
            #1;
            if (t <= FC) begin
                chk($sformatf("tx d=%h t=%0d", d, t), tx, ref_bit(d, (t - 1) / C));
                chk($sformatf("busy d=%h t=%0d", d, t), busy, 1'b1);
                chk($sformatf("done d=%h t=%0d", d, t), done, 1'b0);
            end else begin
                chk($sformatf("tx end d=%h", d), tx, 1'b1);
                chk($sformatf("busy end d=%h", d), busy, 1'b0);
                chk($sformatf("done end d=%h", d), done, 1'b1);
            end
            start   = keep;
            data_in = DW'($urandom);
            if (t == poke) start = 1'b1;
            if (t == FC + 1 && keep) data_in = next_d;
        end
    endtask

    initial begin
        logic [DW-1:0] rd;

        rst_n = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst tx", tx, 1'b1);
            chk("rst busy", busy, 1'b0);
            chk("rst done", done, 1'b0);
        end
        rst_n = 1'b1;
        idle_cycles(20, "idle");

        frame(8'hA5, 1'b0, '0, 0);
        idle_cycles(1, "after a5");

        frame(8'h07, 1'b0, '0, 0);
        idle_cycles(1, "after 07");
        frame(8'h03, 1'b0, '0, 0);
        idle_cycles(1, "after 03");

        frame(8'h55, 1'b0, '0, FC / 2);
        idle_cycles(3, "after 55");

        frame(8'h00, 1'b1, 8'h81, 0);
        frame(8'h81, 1'b0, '0, 0);
        idle_cycles(2, "after b2b");

        repeat (6) begin
            rd = DW'($urandom);
            frame(rd, 1'b0, '0, $urandom_range(2, FC - 1));
            idle_cycles($urandom_range(1, 3), "rand gap");
        end

        rd      = DW'($urandom);
        start   = 1'b1;
        data_in = rd;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4 * C + 1) @(posedge clk);
        #1;
        chk("pre-abort busy", busy, 1'b1);
        chk("pre-abort tx", tx, rd[3]);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort tx", tx, 1'b1);
        chk("abort busy", busy, 1'b0);
        chk("abort done", done, 1'b0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("abort hold tx", tx, 1'b1);
            chk("abort hold busy", busy, 1'b0);
        end
        rst_n = 1'b1;
        idle_cycles(3, "post-abort");
        frame(8'h3C, 1'b0, '0, 0);
        idle_cycles(2, "final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
# uart_tx

UART transmitter: serialises one parallel data word per request into an asynchronous frame. The frame is a start bit, DATA_W data bits LSB first, an optional even-parity bit and one stop bit. It is the transmit-side counterpart of the UART receiver in the same design. It sits between the user logic (start/data handshake) and the serial line pin, and shares the system clock and reset.

## Interface
- CLKS_PER_BIT, default 434 (50 MHz / 115200 Bd): clock cycles per serial bit; legal range ≥ 2.
- DATA_W, default 8: data bits per frame; legal range 5..9.

- clk  input  1  system clock, posedge active.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- start  input  1  transmit request, sampled on posedge clk; honoured only while idle.
- data_in  input  DATA_W  word to send; captured in the cycle start is accepted.
- tx  output  1  serial line, registered; idle/mark level = 1.
- busy  output  1  high while a frame is in progress.
- done  output  1  one-cycle pulse after the stop bit completes.

## Operation
- FSM states: IDLE → START → DATA → (PARITY) → STOP → IDLE.
- Reset (async, rst_n=0) forces the following values:
  - state=IDLE, tx=1, busy=0, done=0.
  - Baud counter, bit index and shift register all 0.
  - Reset mid-frame aborts the frame immediately; tx returns to 1 asynchronously.
- IDLE:
  - tx=1, busy=0.
  - On start=1 at a posedge: latch data_in into the shift register, clear the baud counter and go to START.
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 in every non-IDLE state.
  - The bit-end condition is counter == CLKS_PER_BIT-1; the counter then wraps to 0 and the FSM advances.
  - Counter width is $clog2(CLKS_PER_BIT).
- START: tx=0 for one bit time.
- DATA:
  - tx = shift register bit 0; the register shifts right at each bit end.
  - The bit index counts 0..DATA_W-1.
  - Leave DATA after bit DATA_W-1.
- PARITY (macro only): tx = XOR of all latched data bits (even parity) for one bit time.
- STOP: tx=1 for one bit time, then go to IDLE and pulse done.
- start while busy=1 is ignored. The frame in flight is unaffected and no request is queued.
- data_in changes after acceptance have no effect on the current frame.
- start held high continuously sends back-to-back frames, each re-sampling data_in at its acceptance.

## Timing
- C = CLKS_PER_BIT and N = frame bits: DATA_W+2 without the macro, DATA_W+3 with it.
- start sampled high at edge k:
  - tx=0 and busy=1 from edge k+1.
  - Bit j (start bit = bit 0) is driven on tx from edge k+1+j·C for exactly C cycles.
- Stop bit ends at edge k+1+N·C:
  - busy=0 and done=1 for that one cycle.
  - tx stays 1.
- A start asserted in the done cycle is accepted; the next start bit begins one cycle later. Minimum frame period is N·C+1 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is compiled in. An even-parity bit is inserted between the last data bit and stop. Frame = DATA_W+3 bits.
- Undefined: there is no PARITY state and no parity logic. DATA goes directly to STOP. Frame = DATA_W+2 bits.

## Test plan
1. Reset and idle. Hold rst_n=0 for 3 cycles, then release with start=0 for 20 cycles → tx=1, busy=0, done=0 throughout.
2. Single frame, no macro (C=4, DATA_W=8). Pulse start with data_in=0xA5 → tx sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 4 cycles. busy is high for 40 cycles, and done pulses once at cycle 41.
3. Parity, with macro (C=4). Send 0x07 → parity bit=1 and frame is 11 bits/44 cycles. Send 0x03 → parity bit=0.
4. Start ignored while busy. Pulse start with 0x55, then at mid-frame pulse start with 0xFF → only the 0x55 frame is transmitted and done pulses once.
5. Back-to-back frames. Hold start=1 with data_in=0x00, switching to 0x81 in the first done cycle → the second frame's start bit begins 1 cycle after done and carries 0x81.
6. Reset mid-frame. Assert rst_n=0 during data bit 3 → tx=1 and busy=0 asynchronously. After release, a new start with 0x3C produces a clean full frame.
